// File: rtl/mem_block_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_responder
// Description : Block-granular backing memory for a cache controller.
//               It accepts one request at a time: a block read (allocate) or
//               a block write (evict). Each accepted request completes with a
//               single-cycle mem_req_ready pulse exactly LATENCY cycles after
//               the accept edge. A request held high after completion is
//               parked in RELEASE until the enable drops, so it is never
//               serviced twice.
//
// Parameters  : WORD_SIZE        address width in bits
//               BLOCK_DATA_WIDTH block transfer width in bits (64 bytes)
//               MEM_BLOCKS       storage depth in blocks (power of two)
//               LATENCY          accept-to-ready latency in cycles (1..15)
//
// Ports       : clk              sole clock, rising edge
//               rst              synchronous active-high reset
//               mem_req_enable   request valid, held until serviced
//               mem_req_rw       0 = block read, 1 = block write
//               mem_req_addr     byte address of the block
//               mem_req_dataout  write block from the controller
//               mem_req_datain   read block to the controller
//               mem_req_ready    one-cycle completion pulse
//               rd_count         completed reads, saturating (stats build)
//               wr_count         completed writes, saturating (stats build)
//
// Options     : MEM_REQ_STATS_EN adds the rd_count / wr_count outputs.
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_block_responder #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_DATA_WIDTH = 512,
    parameter int MEM_BLOCKS       = 64,
    parameter int LATENCY          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_req_enable,
    input  logic                        mem_req_rw,
    input  logic [WORD_SIZE-1:0]        mem_req_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
    output logic                        mem_req_ready
`ifdef MEM_REQ_STATS_EN
    ,
    output logic [15:0]                 rd_count,
    output logic [15:0]                 wr_count
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_IDX_W    = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
    // Byte offset inside a 64-byte block; the block index starts above it.
    localparam int         c_OFS_W    = 6;
    localparam logic [3:0] c_LAT_LOAD = 4'(LATENCY - 1);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;

    // Transaction latched at accept; later input changes are ignored.
    logic                        rw_q;
    logic [c_IDX_W-1:0]          idx_q;
    logic [BLOCK_DATA_WIDTH-1:0] wdata_q;

    logic [BLOCK_DATA_WIDTH-1:0] rdata_q;
    logic [BLOCK_DATA_WIDTH-1:0] mem_q [MEM_BLOCKS];

    logic                        w_accept;
    logic                        w_enter_resp;
    logic                        w_commit_wr;
    logic                        w_commit_rd;
    logic [c_IDX_W-1:0]          w_req_idx;
    logic                        w_unused_addr;

    // Offset bits and bits above the index do not select storage, so
    // addresses wrap modulo MEM_BLOCKS.
    assign w_req_idx     = mem_req_addr[c_OFS_W +: c_IDX_W];
    assign w_unused_addr = ^mem_req_addr;

    assign w_accept     = (state_q == S_IDLE) && mem_req_enable;
    assign w_enter_resp = (state_d == S_RESPOND) && (state_q != S_RESPOND);

    // A reset on the edge that would enter RESPOND aborts the transaction,
    // so storage and the read register are only touched with rst low.
    assign w_commit_wr = w_enter_resp && rw_q_or_new(1'b1) && !rst;
    assign w_commit_rd = w_enter_resp && rw_q_or_new(1'b0) && !rst;

    // With LATENCY=1 the accept edge itself enters RESPOND, before the
    // latched registers are loaded, so the live request is used then.
    function automatic logic rw_q_or_new(input logic want_wr);
        logic rw_sel;
        rw_sel = (state_q == S_IDLE) ? mem_req_rw : rw_q;
        return (rw_sel == want_wr);
    endfunction

    logic [c_IDX_W-1:0]          w_act_idx;
    logic [BLOCK_DATA_WIDTH-1:0] w_act_wdata;

    assign w_act_idx   = (state_q == S_IDLE) ? w_req_idx       : idx_q;
    assign w_act_wdata = (state_q == S_IDLE) ? mem_req_dataout : wdata_q;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req_enable) begin
                    cnt_d = c_LAT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = S_RESPOND;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Wait for the controller to drop its request so that a
                // held enable is not taken as a new transaction.
                if (!mem_req_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (w_accept) begin
            rw_q    <= mem_req_rw;
            idx_q   <= w_req_idx;
            wdata_q <= mem_req_dataout;
        end
    end

    // ------------------------------------------------------------------------
    // Block storage (contents survive reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            mem_q[w_act_idx] <= w_act_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read data register: only a completed read updates it
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (w_commit_rd) begin
            rdata_q <= mem_q[w_act_idx];
        end
    end

    assign mem_req_datain = rdata_q;
    assign mem_req_ready  = (state_q == S_RESPOND);

`ifdef MEM_REQ_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating transaction counters
    // ------------------------------------------------------------------------
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            if (w_commit_rd && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (w_commit_wr && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_block_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_block_responder
// Description : Self-checking bench for mem_block_responder. A bench-side
//               model of the block storage produces the expected read data,
//               which is queued when a read is driven and popped when the
//               ready pulse arrives.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_block_responder;

    localparam int c_LAT = 4;
    localparam int c_BW  = 512;
    localparam int c_NB  = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic            rw  = 1'b0;
    logic [31:0]     addr = '0;
    logic [c_BW-1:0] dout = '0;
    logic [c_BW-1:0] din;
    logic            ready;
`ifdef MEM_REQ_STATS_EN
    logic [15:0]     rd_count;
    logic [15:0]     wr_count;
`endif

    mem_block_responder #(
        .WORD_SIZE        (32),
        .BLOCK_DATA_WIDTH (c_BW),
        .MEM_BLOCKS       (c_NB),
        .LATENCY          (c_LAT)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_enable  (en),
        .mem_req_rw      (rw),
        .mem_req_addr    (addr),
        .mem_req_dataout (dout),
        .mem_req_datain  (din),
        .mem_req_ready   (ready)
`ifdef MEM_REQ_STATS_EN
        ,
        .rd_count        (rd_count),
        .wr_count        (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [c_BW-1:0] model [c_NB];
    logic [c_BW-1:0] exp_q [$];
    logic [c_BW-1:0] last_rd = '0;

    task automatic check(input string tag, input logic [c_BW-1:0] obs,
                         input logic [c_BW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_BW-1:0] blk(input logic [31:0] base);
        logic [c_BW-1:0] b;
        for (int i = 0; i < 16; i++) begin
            b[i*32 +: 32] = base + 32'(i);
        end
        return b;
    endfunction

    // One complete transaction. Inputs change #1 after a rising edge and
    // outputs are sampled at the same point.
    task automatic do_req(input logic w, input logic [31:0] a,
                          input logic [c_BW-1:0] d, input int hold,
                          input bit scramble);
        int              lat;
        int              extra;
        logic [5:0]      idx;
        logic [c_BW-1:0] e;
        idx  = a[11:6];
        en   = 1'b1;
        rw   = w;
        addr = a;
        dout = d;
        if (w) model[idx] = d;
        else   exp_q.push_back(model[idx]);
        @(posedge clk); #1;                      // accept edge
        if (scramble) begin
            addr = a ^ 32'h0000_0100;
            dout = ~d;
        end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i;
                break;
            end
        end
        check(w ? "wr_latency" : "rd_latency", c_BW'(lat), c_BW'(c_LAT));
        if (!w) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("rd_data", din, e);
            last_rd = e;
        end else begin
            check("wr_keeps_datain", din, last_rd);
        end
        extra = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (ready) extra++;
        end
        check("single_pulse", c_BW'(extra), '0);
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst     = 1'b0;
        last_rd = '0;
    endtask

    initial begin : main
        int pulses;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst_ready", c_BW'(ready), '0);
        check("rst_datain", din, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known contents for the indices used by abort/scramble tests.
        do_req(1'b1, 32'h0000_0080, blk(32'h1111_0000), 1, 1'b0);
        do_req(1'b1, 32'h0000_01C0, blk(32'h7777_0000), 1, 1'b0);

        // Write then read.
        do_req(1'b1, 32'h0000_0040, blk(32'hDEAD_BEEF), 1, 1'b0);
        do_req(1'b0, 32'h0000_0040, '0, 1, 1'b0);

        // Address wrap and ignored offset bits.
        do_req(1'b1, 32'h0000_1040, blk(32'hCAFE_BABE), 1, 1'b0);
        do_req(1'b0, 32'h0000_0040, '0, 1, 1'b0);
        do_req(1'b0, 32'h0000_007F, '0, 1, 1'b0);

        // Highest index, reached via a low and a high alias.
        do_req(1'b1, 32'h0000_0FC0, blk(32'h3F3F_0000), 1, 1'b0);
        do_req(1'b0, 32'hFFFF_FFC0, '0, 1, 1'b0);

        // Held enable: exactly one pulse over 10 extra cycles.
        do_req(1'b0, 32'h0000_0080, '0, 10, 1'b0);

        // Input changes during WAIT are ignored.
        do_req(1'b1, 32'h0000_00C0, blk(32'h3333_0000), 1, 1'b1);
        do_req(1'b0, 32'h0000_00C0, '0, 1, 1'b0);
        do_req(1'b0, 32'h0000_01C0, '0, 1, 1'b0);

        // Reset two cycles after accepting a write: aborted, no pulse.
        en     = 1'b1;
        rw     = 1'b1;
        addr   = 32'h0000_0080;
        dout   = blk(32'hFACE_CAFE);
        pulses = 0;
        @(posedge clk); #1;                      // accept edge
        repeat (2) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk); #1;
        if (ready) pulses++;
        rst     = 1'b0;
        last_rd = '0;
        check("abort_datain", din, '0);
        repeat (6) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check("abort_no_pulse", c_BW'(pulses), '0);
        do_req(1'b0, 32'h0000_0080, '0, 1, 1'b0);

        // Statistics: 3 writes and 2 reads from a clean reset.
        pulse_reset();
        do_req(1'b1, 32'h0000_0200, blk(32'hA000_0000), 1, 1'b0);
        do_req(1'b1, 32'h0000_0240, blk(32'hA100_0000), 1, 1'b0);
        do_req(1'b0, 32'h0000_0200, '0, 1, 1'b0);
        do_req(1'b1, 32'h0000_0280, blk(32'hA200_0000), 1, 1'b0);
        do_req(1'b0, 32'h0000_0280, '0, 1, 1'b0);
`ifdef MEM_REQ_STATS_EN
        check("wr_count", c_BW'(wr_count), c_BW'(3));
        check("rd_count", c_BW'(rd_count), c_BW'(2));
`endif
        pulse_reset();
        check("post_rst_datain", din, '0);
`ifdef MEM_REQ_STATS_EN
        check("wr_count_rst", c_BW'(wr_count), '0);
        check("rd_count_rst", c_BW'(rd_count), '0);
`endif
        // Storage survives reset.
        do_req(1'b0, 32'h0000_0240, '0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_block_responder.md
MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

Interface
REQ-001 Parameter WORD_SIZE, default 32: address width in bits.
REQ-002 Parameter BLOCK_DATA_WIDTH, default 512: block transfer width in bits (16 words, 64 bytes).
REQ-003 Parameter MEM_BLOCKS, default 64: storage depth in blocks, power of two.
REQ-004 Parameter LATENCY, default 4: cycles from request accept to mem_req_ready, range 1..15.
REQ-005 clk  input  1  sole clock; all logic on rising edge; one clock, reset synchronous and active-high.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 mem_req_enable  input  1  request valid from the cache controller, held high until serviced.
REQ-008 mem_req_rw  input  1  0 = block read (allocate), 1 = block write (evict).
REQ-009 mem_req_addr  input  WORD_SIZE  byte address of the block.
REQ-010 mem_req_dataout  input  BLOCK_DATA_WIDTH  write block from the controller.
REQ-011 mem_req_datain  output  BLOCK_DATA_WIDTH  read block to the controller.
REQ-012 mem_req_ready  output  1  one-cycle completion pulse.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT, RESPOND, RELEASE.
REQ-014 Block index SHALL be mem_req_addr[6 +: log2(MEM_BLOCKS)]; bits [5:0] and bits above the index SHALL be ignored (addresses wrap modulo MEM_BLOCKS).
REQ-015 In IDLE with mem_req_enable=1 at a rising edge, the block SHALL latch rw, index and write data and enter WAIT with latency counter loaded to LATENCY-1.
REQ-016 In WAIT the counter SHALL decrement each cycle; when it is 0 the next edge SHALL enter RESPOND, so mem_req_ready is high exactly LATENCY cycles after the accept edge.
REQ-017 LATENCY=1 SHALL skip WAIT: accept edge goes directly to RESPOND.
REQ-018 On the edge entering RESPOND, a write SHALL commit the latched block to storage; a read SHALL load mem_req_datain from storage at the latched index.
REQ-019 mem_req_ready SHALL be high for exactly the one cycle spent in RESPOND; RESPOND SHALL go to RELEASE unconditionally.
REQ-020 RELEASE SHALL hold until mem_req_enable=0 is sampled, then go to IDLE; a held enable SHALL never be serviced twice.
REQ-021 mem_req_enable, addr, rw and dataout changes in WAIT, RESPOND or RELEASE SHALL be ignored; latched values govern the transaction.
REQ-022 mem_req_datain SHALL hold its value until the next read completes; writes SHALL not change it.
REQ-023 A read after a write to the same index SHALL return the written block.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, mem_req_ready=0, mem_req_datain=0, and latency counter=0.
REQ-025 Reset in WAIT SHALL abort the transaction with no storage update; reset in RESPOND SHALL leave an already-committed write in place.
REQ-026 Storage contents SHALL not be cleared by reset.

Configuration
REQ-027 Macro MEM_REQ_STATS_EN, when defined, SHALL add outputs rd_count and wr_count (16 bits each).
REQ-028 With MEM_REQ_STATS_EN defined, the matching counter SHALL increment on each RESPOND entry, saturate at 16'hFFFF, and reset to 0.
REQ-029 Without MEM_REQ_STATS_EN, the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Write then read: write addr 0x0000_0040 with data word i = 0xDEADBEEF+i, then read 0x0000_0040 -> ready pulses 4 cycles after each accept; datain equals the written block.
REQ-031 Wrap: write 0x0000_1040 (index 1 for MEM_BLOCKS=64) with 0xCAFEBABE pattern, read 0x0000_0040 -> returns the 0xCAFEBABE block.
REQ-032 Held enable: hold enable=1 for 10 cycles after a read -> exactly one ready pulse; the FSM stays in RELEASE until enable drops.
REQ-033 Reset mid-WAIT: write 0xFACECAFE block to index 2, assert rst 2 cycles after accept, then read index 2 -> old contents returned, no ready pulse for the aborted request.
REQ-034 Input changes: change addr and dataout during WAIT -> write lands at the originally latched index with the originally latched data.
REQ-035 Stats (MEM_REQ_STATS_EN): 3 writes and 2 reads -> wr_count=3, rd_count=2; after rst both are 0.
